// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cache_pkg                                                        |
// | Purpose : Shared types and width helpers for the set-associative cache.    |
// |           Holds the controller state encoding and the functions that      |
// |           derive the index, tag and age field widths from the parameters. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WB        = 3'd2,
    FILL      = 3'd3,
    FILL_WAIT = 3'd4,
    RESP      = 3'd5
  } state_t;

  function automatic int calc_index_w(input int sets_log2);
    return sets_log2;
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets_log2);
    return addr_w - sets_log2 - 2;
  endfunction

  // A one-way cache still carries a 1-bit age/way field so that every
  // vector in the design has a legal, non-zero width.
  function automatic int calc_age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cache_lru                                                        |
// | Purpose : Combinational true-LRU helper for one cache set.                 |
// |           Produces the age vector after touching i_access_way and picks   |
// |           the replacement victim (lowest invalid way, else the oldest).   |
// | Ports   : i_ages       current per-way ages of the set                     |
// |           i_valid      per-way valid bits of the set                       |
// |           i_access_way way being hit or installed                         |
// |           o_next_ages  ages after the access                              |
// |           o_victim_way way to replace on a miss                           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS-1:0][AGE_W-1:0] i_ages,
  input  logic [WAYS-1:0]            i_valid,
  input  logic [AGE_W-1:0]           i_access_way,
  output logic [WAYS-1:0][AGE_W-1:0] o_next_ages,
  output logic [AGE_W-1:0]           o_victim_way
);

  localparam logic [AGE_W-1:0] c_oldest = AGE_W'(WAYS - 1);

  logic [AGE_W-1:0] w_acc_age;
  logic             w_found;

  // Ages younger than the accessed way shift up by one; the accessed way
  // becomes youngest. This keeps each set's ages a permutation.
  always_comb begin
    w_acc_age = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == i_access_way) w_acc_age = i_ages[i];
    end
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == i_access_way)  o_next_ages[i] = '0;
      else if (i_ages[i] < w_acc_age) o_next_ages[i] = i_ages[i] + 1'b1;
      else                            o_next_ages[i] = i_ages[i];
    end
  end

  always_comb begin
    o_victim_way = '0;
    w_found      = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found && !i_valid[i]) begin
        o_victim_way = AGE_W'(i);
        w_found      = 1'b1;
      end
    end
    if (!w_found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (i_ages[i] == c_oldest) o_victim_way = AGE_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/set_assoc_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : set_assoc_cache                                                  |
// | Purpose : N-way set-associative, write-back, write-allocate cache with     |
// |           true-LRU replacement, one word per line, one request in flight. |
// | Ports   : clk/reset              clock, synchronous active-high reset      |
// |           req_*                  core load/store request (valid/ready)     |
// |           resp_*                 one-cycle completion pulse, data, hit    |
// |           mem_req_*              writeback / refill request to memory     |
// |           mem_resp_*             refill data return                        |
// |           hit_count/miss_count   saturating statistics                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int SETS_LOG2 = 6,
  parameter int WAYS      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int INDEX_W = calc_index_w(SETS_LOG2);
  localparam int TAG_W   = calc_tag_w(ADDR_W, SETS_LOG2);
  localparam int AGE_W   = calc_age_w(WAYS);
  localparam int SETS    = 1 << SETS_LOG2;

  state_t r_state, w_state_next;

  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [AGE_W-1:0]  r_victim;
  logic [31:0]       r_hit_count, r_miss_count;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_hit;

  logic [TAG_W-1:0]  r_tags  [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [AGE_W-1:0]  r_age   [SETS][WAYS];

  logic [INDEX_W-1:0]            w_index;
  logic [TAG_W-1:0]              w_tag;
  logic [WAYS-1:0][AGE_W-1:0]    w_set_age, w_next_age;
  logic [WAYS-1:0]               w_set_valid;
  logic                          w_hit;
  logic [AGE_W-1:0]              w_hit_way, w_lru_victim, w_access_way;
  logic [DATA_W-1:0]             w_hit_data, w_victim_data;
  logic [TAG_W-1:0]              w_victim_tag;
  logic                          w_lru_victim_dirty;

  logic              w_line_we, w_line_dirty, w_lru_upd, w_victim_we;
  logic [AGE_W-1:0]  w_line_way;
  logic [DATA_W-1:0] w_line_data, w_resp_data;
  logic              w_hit_inc, w_miss_inc, w_resp_we, w_resp_hit;
  logic              w_unused;

  assign w_index  = r_addr[SETS_LOG2+1:2];
  assign w_tag    = r_addr[ADDR_W-1:SETS_LOG2+2];
  assign w_unused = &{1'b0, r_addr[1:0]};

  // Tag match plus per-set views of the ways for the latched address.
  always_comb begin
    w_hit              = 1'b0;
    w_hit_way          = '0;
    w_hit_data         = '0;
    w_victim_tag       = '0;
    w_victim_data      = '0;
    w_lru_victim_dirty = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      w_set_age[i]   = r_age[w_index][i];
      w_set_valid[i] = r_valid[w_index][i];
      if (r_valid[w_index][i] && (r_tags[w_index][i] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_way  = AGE_W'(i);
        w_hit_data = r_data[w_index][i];
      end
      if (AGE_W'(i) == r_victim) begin
        w_victim_tag  = r_tags[w_index][i];
        w_victim_data = r_data[w_index][i];
      end
      if (AGE_W'(i) == w_lru_victim) begin
        w_lru_victim_dirty = r_valid[w_index][i] && r_dirty[w_index][i];
      end
    end
  end

  // In LOOKUP the touched way is the hit way or the freshly chosen victim;
  // later states always install into the victim latched in LOOKUP.
  always_comb begin
    w_access_way = r_victim;
    if (r_state == LOOKUP) w_access_way = w_hit ? w_hit_way : w_lru_victim;
  end

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .i_ages       (w_set_age),
    .i_valid      (w_set_valid),
    .i_access_way (w_access_way),
    .o_next_ages  (w_next_age),
    .o_victim_way (w_lru_victim)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_line_we    = 1'b0;
    w_line_way   = r_victim;
    w_line_data  = r_wdata;
    w_line_dirty = 1'b0;
    w_lru_upd    = 1'b0;
    w_victim_we  = 1'b0;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_resp_we    = 1'b0;
    w_resp_data  = r_wdata;
    w_resp_hit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          w_hit_inc    = 1'b1;
          w_lru_upd    = 1'b1;
          w_resp_we    = 1'b1;
          w_resp_hit   = 1'b1;
          w_resp_data  = r_write ? r_wdata : w_hit_data;
          w_line_we    = r_write;
          w_line_way   = w_hit_way;
          w_line_dirty = 1'b1;
          w_state_next = RESP;
        end else begin
          w_miss_inc  = 1'b1;
          w_victim_we = 1'b1;
          if (w_lru_victim_dirty) begin
            w_state_next = WB;
          end else if (!r_write) begin
            w_state_next = FILL;
          end else begin
            // Store miss into a clean/invalid way installs without a refill.
            w_line_we    = 1'b1;
            w_line_way   = w_lru_victim;
            w_line_dirty = 1'b1;
            w_lru_upd    = 1'b1;
            w_resp_we    = 1'b1;
            w_state_next = RESP;
          end
        end
      end
      WB: begin
        if (mem_req_ready) begin
          if (r_write) begin
            w_line_we    = 1'b1;
            w_line_dirty = 1'b1;
            w_lru_upd    = 1'b1;
            w_resp_we    = 1'b1;
            w_state_next = RESP;
          end else begin
            w_state_next = FILL;
          end
        end
      end
      FILL: begin
        if (mem_req_ready) w_state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          w_line_we    = 1'b1;
          w_line_data  = mem_resp_rdata;
          w_lru_upd    = 1'b1;
          w_resp_we    = 1'b1;
          w_resp_data  = mem_resp_rdata;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_victim     <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_resp_rdata <= '0;
      r_resp_hit   <= 1'b0;
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_victim_we) r_victim <= w_lru_victim;
      if (w_hit_inc  && (r_hit_count  != '1)) r_hit_count  <= r_hit_count  + 32'd1;
      if (w_miss_inc && (r_miss_count != '1)) r_miss_count <= r_miss_count + 32'd1;
      if (w_resp_we) begin
        r_resp_rdata <= w_resp_data;
        r_resp_hit   <= w_resp_hit;
      end
    end
  end

  // One register slice per (set, way) so every entry has a single driver.
  for (genvar s = 0; s < SETS; s++) begin : g_set
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      always_ff @(posedge clk) begin
        if (reset) begin
          r_tags[s][w]  <= '0;
          r_data[s][w]  <= '0;
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= AGE_W'(w);
        end else begin
          if (w_line_we && (w_index == INDEX_W'(s)) && (w_line_way == AGE_W'(w))) begin
            r_tags[s][w]  <= w_tag;
            r_data[s][w]  <= w_line_data;
            r_valid[s][w] <= 1'b1;
            r_dirty[s][w] <= w_line_dirty;
          end
          if (w_lru_upd && (w_index == INDEX_W'(s))) r_age[s][w] <= w_next_age[w];
        end
      end
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign resp_valid    = (r_state == RESP);
  assign resp_rdata    = r_resp_rdata;
  assign resp_hit      = r_resp_hit;
  assign mem_req_valid = (r_state == WB) || (r_state == FILL);
  assign mem_req_write = (r_state == WB);
  assign mem_req_addr  = (r_state == WB)   ? {w_victim_tag, w_index, 2'b00} :
                         (r_state == FILL) ? {r_addr[ADDR_W-1:2], 2'b00}    : '0;
  assign mem_req_wdata = (r_state == WB) ? w_victim_data : '0;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_set_assoc_cache                                               |
// | Purpose : Self-checking bench for set_assoc_cache (4 ways, 64 sets).       |
// |           The bench plays the memory and keeps a recency-list model of    |
// |           each set plus a word-addressed backing store.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_set_assoc_cache;

  localparam int DATA_W = 32, ADDR_W = 16, SETS_LOG2 = 6, WAYS = 4, SETS = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_hit;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic [31:0]       hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_cache #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETS_LOG2(SETS_LOG2), .WAYS(WAYS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per set: lines ordered most-recent first; m_cnt lines are valid.
  logic [15:0] m_line  [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int          m_cnt   [SETS];
  logic [31:0] mem_model [logic [15:0]];
  logic [31:0] exp_hits, exp_misses;
  logic [15:0] last_wb_addr, last_fill_addr;
  logic [31:0] last_wb_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic mem_read(input logic [15:0] a, output logic [31:0] d);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    d = mem_model[a];
  endtask

  task automatic model_access(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                              output bit hit, output bit wb, output logic [15:0] wb_addr,
                              output logic [31:0] wb_data, output bit fill, output logic [31:0] rdata);
    int          s;
    int          pos;
    logic [15:0] line;
    logic [31:0] n_data;
    bit          n_dirty;
    s    = int'(addr[7:2]);
    line = {addr[15:2], 2'b00};
    pos  = -1;
    hit = 0; wb = 0; wb_addr = '0; wb_data = '0; fill = 0;
    for (int i = 0; i < m_cnt[s]; i++) if (m_line[s][i] == line) pos = i;
    if (pos >= 0) begin
      hit     = 1;
      n_data  = wr ? wd : m_data[s][pos];
      n_dirty = wr ? 1'b1 : m_dirty[s][pos];
      exp_hits++;
    end else begin
      exp_misses++;
      if (m_cnt[s] == WAYS) begin
        pos = WAYS - 1;
        if (m_dirty[s][pos]) begin
          wb = 1; wb_addr = m_line[s][pos]; wb_data = m_data[s][pos];
          mem_model[wb_addr] = wb_data;
        end
      end else begin
        pos = m_cnt[s];
        m_cnt[s]++;
      end
      if (wr) begin
        n_data = wd; n_dirty = 1;
      end else begin
        fill = 1; mem_read(line, n_data); n_dirty = 0;
      end
    end
    for (int i = pos; i > 0; i--) begin
      m_line[s][i] = m_line[s][i-1]; m_data[s][i] = m_data[s][i-1]; m_dirty[s][i] = m_dirty[s][i-1];
    end
    m_line[s][0] = line; m_data[s][0] = n_data; m_dirty[s][0] = n_dirty;
    rdata = n_data;
  endtask

  // One request end to end, with the bench acting as memory. 'stall' holds
  // mem_req_ready low on the first memory request; 'poke' drives stray
  // req_valid pulses during that stall.
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input int stall, input bit poke);
    bit          e_hit, e_wb, e_fill, fill_pend, got, cap;
    logic [15:0] e_wb_addr, cap_addr;
    logic [31:0] e_wb_data, e_rdata, cap_wdata;
    int          cyc, n_wb, n_fill, resp_cnt, stall_left, guard;
    model_access(wr, addr, wd, e_hit, e_wb, e_wb_addr, e_wb_data, e_fill, e_rdata);
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; cyc = 1;
    n_wb = 0; n_fill = 0; fill_pend = 0; resp_cnt = 0; got = 0; cap = 0;
    stall_left = stall; cap_addr = '0; cap_wdata = '0;
    while (!got && cyc < 100) begin
      mem_resp_valid = 0;
      req_valid      = 0;
      if (resp_valid) begin
        got = 1;
      end else begin
        check("req_ready_busy", req_ready, 0);
        if (fill_pend) begin
          if (resp_cnt == 0) begin
            mem_resp_valid = 1; mem_resp_rdata = e_rdata; fill_pend = 0;
          end else resp_cnt--;
        end
        if (stall_left > 0 && (mem_req_valid || cap)) begin
          mem_req_ready = 0;
          if (!cap) begin
            cap = 1; cap_addr = mem_req_addr; cap_wdata = mem_req_wdata;
          end else begin
            check("stall_valid_hold", mem_req_valid, 1);
            check("stall_addr_hold", mem_req_addr, cap_addr);
            check("stall_wdata_hold", mem_req_wdata, cap_wdata);
          end
          stall_left--;
          if (poke) begin
            req_valid = 1; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
          end
        end else if (mem_req_valid) begin
          mem_req_ready = ($urandom_range(0, 2) != 0);
          if (mem_req_ready) begin
            if (mem_req_write) begin
              n_wb++;
              check("wb_addr", mem_req_addr, e_wb_addr);
              check("wb_data", mem_req_wdata, e_wb_data);
              last_wb_addr = mem_req_addr; last_wb_data = mem_req_wdata;
            end else begin
              n_fill++;
              check("fill_addr", mem_req_addr, {addr[15:2], 2'b00});
              last_fill_addr = mem_req_addr;
              fill_pend = 1; resp_cnt = $urandom_range(0, 3);
            end
          end
        end else begin
          mem_req_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_req_ready = 0; mem_resp_valid = 0; req_valid = 0;
    check("resp_timeout", got, 1);
    if (got) begin
      check("resp_hit", resp_hit, e_hit);
      check("resp_rdata", resp_rdata, e_rdata);
      check("hit_count", hit_count, exp_hits);
      check("miss_count", miss_count, exp_misses);
      check("wb_count", n_wb, e_wb ? 1 : 0);
      check("fill_count", n_fill, e_fill ? 1 : 0);
      if (!e_wb && !e_fill) check("latency", cyc, 2);
      @(posedge clk); #1;
      check("resp_one_cycle", resp_valid, 0);
      check("req_ready_after", req_ready, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int          guard;
    reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    last_wb_addr = '0; last_wb_data = '0; last_fill_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;

    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_write", mem_req_write, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_mem_wdata", mem_req_wdata, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);

    // Cold load miss then the same load hits.
    mem_model[16'h0104] = 32'hDEADBEEF;
    do_req(0, 16'h0104, 0, 0, 0);
    check("first_fill_addr", last_fill_addr, 16'h0104);
    check("first_rdata", resp_rdata, 32'hDEADBEEF);
    do_req(0, 16'h0104, 0, 0, 0);
    check("second_hit", resp_hit, 1);

    // Fill set 1, touch 0x0204, then evict the least recent line (0x0104).
    do_req(1, 16'h0104, 32'h11, 0, 0);
    do_req(1, 16'h0204, 32'h22, 0, 0);
    do_req(1, 16'h0304, 32'h33, 0, 0);
    do_req(1, 16'h0404, 32'h44, 0, 0);
    do_req(0, 16'h0204, 0, 0, 0);
    do_req(0, 16'h0504, 0, 0, 0);
    check("lru_wb_addr", last_wb_addr, 16'h0104);
    check("lru_wb_data", last_wb_data, 32'h11);
    check("lru_fill_addr", last_fill_addr, 16'h0504);

    // Writeback held off for 5 cycles while stray requests arrive.
    do_req(0, 16'h0604, 0, 5, 1);
    check("stall_wb_addr", last_wb_addr, 16'h0304);
    check("stall_wb_data", last_wb_data, 32'h33);

    // Store miss into an empty set: no memory traffic, then a load hit.
    do_req(1, 16'h0808, 32'hA5A5A5A5, 0, 0);
    do_req(0, 16'h0808, 0, 0, 0);
    check("store_miss_readback", resp_rdata, 32'hA5A5A5A5);

    // Spurious refill data while idle.
    mem_resp_valid = 1; mem_resp_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    check("spur_resp_valid", resp_valid, 0);
    check("spur_req_ready", req_ready, 1);
    check("spur_mem_valid", mem_req_valid, 0);
    @(posedge clk); #1;
    check("spur_resp_valid2", resp_valid, 0);
    do_req(0, 16'h0808, 0, 0, 0);
    check("spur_no_corrupt", resp_rdata, 32'hA5A5A5A5);

    // Random traffic over a few sets with more tags than ways.
    for (int n = 0; n < 300; n++) begin
      a = 16'(($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 0, 0);
    end

    // Reset while waiting for refill data; the late data must be ignored.
    mem_model[16'h0C10] = 32'hCAFEF00D;
    req_valid = 1; req_write = 0; req_addr = 16'h0C10; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 0;
    guard = 0;
    while (!mem_req_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    check("rf_fill_seen", mem_req_valid, 1);
    check("rf_fill_addr", mem_req_addr, 16'h0C10);
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    check("rf_wait_bus_idle", mem_req_valid, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("rf_req_ready", req_ready, 1);
    check("rf_hits", hit_count, 0);
    check("rf_misses", miss_count, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h0BADBAD0;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    check("rf_no_resp", resp_valid, 0);
    check("rf_idle", req_ready, 1);
    @(posedge clk); #1;
    check("rf_no_resp2", resp_valid, 0);
    model_reset();
    do_req(0, 16'h0C10, 0, 0, 0);
    check("rf_miss_again", resp_hit, 0);
    check("rf_refill_data", resp_rdata, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
